// File: rtl/autotest_pkg.sv
// Shared types and defaults for the autotest harness around the PRESENT core.
package autotest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KEYGEN,
    RUN,
    CAPTURE,
    DONE
  } driver_state_t;

  localparam logic ENDEC_ENC = 1'b0;
  localparam logic ENDEC_DEC = 1'b1;

  localparam int DEF_BLOCK_SIZE     = 64;
  localparam int DEF_KEY_INPUT_SIZE = 80;
  localparam int DEF_CNT_WIDTH      = 32;
  localparam int DEF_RST_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/present_uut_driver_counter.sv
// Generic saturating up/down counter; a synchronous active-low reset reloads zero.
module present_uut_driver_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Count while enabled, sticking at the end of the range instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (up && (count != '1)) begin
        count <= count + 1'b1;
      end else if (!up && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/present_uut_driver.sv
// Sequencer between the autotest FSM and the PRESENT core under test.
// Optional macro PRESENT_UUT_DRIVER_KEY_CYCLES_EN adds key_cycles_o, the
// key-schedule latency of the last run.
//
// state   | meaning
// IDLE    | UUT held in reset, waiting for start
// LOAD    | vector latched, rst_uut held for RST_CYCLES clocks
// KEYGEN  | UUT running, waiting for end of key schedule
// RUN     | waiting for the enc/dec completion strobe
// CAPTURE | latch block_o_uut and cycle count
// DONE    | raise done, drop busy, put UUT back in reset
module present_uut_driver
  import autotest_pkg::*;
#(
  parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int KEY_INPUT_SIZE = DEF_KEY_INPUT_SIZE,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BLOCK_SIZE-1:0]     vec_block_i,
  input  logic [KEY_INPUT_SIZE-1:0] vec_key_i,
  input  logic                      vec_endec_i,
  output logic                      busy,
  output logic                      done,
  output logic [BLOCK_SIZE-1:0]     result_o,
  output logic [CNT_WIDTH-1:0]      cycles_o,
  output logic                      timeout_o,
`ifdef PRESENT_UUT_DRIVER_KEY_CYCLES_EN
  output logic [CNT_WIDTH-1:0]      key_cycles_o,
`endif
  output logic                      rst_uut,
  output logic [BLOCK_SIZE-1:0]     block_i_uut,
  output logic [KEY_INPUT_SIZE-1:0] key_uut,
  output logic                      endec_uut,
  input  logic [BLOCK_SIZE-1:0]     block_o_uut,
  input  logic                      end_key_signal_uut,
  input  logic                      end_enc_uut,
  input  logic                      end_dec_uut
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LIMIT  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  driver_state_t        state;
  logic [RCW-1:0]       rst_cnt;
  logic [CNT_WIDTH-1:0] count;
  logic                 cnt_rst;
  logic                 cnt_en;
  logic                 strobe;
  logic                 at_limit;

  // Counter is held at zero through LOAD so it starts from 0 as rst_uut drops.
  assign cnt_rst  = rst && (state != LOAD);
  assign cnt_en   = (state == KEYGEN) || (state == RUN);
  assign strobe   = (endec_uut == ENDEC_DEC) ? end_dec_uut : end_enc_uut;
  // >= rather than == so a run that reached RUN on the last allowed cycle
  // still aborts one cycle later if its strobe never arrives.
  assign at_limit = (count >= LIMIT);

  present_uut_driver_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst  (cnt_rst),
    .en   (cnt_en),
    .up   (1'b1),
    .count(count)
  );

  // Sequencer: launch, wait for key schedule and completion, report back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_o   <= 1'b0;
      result_o    <= '0;
      cycles_o    <= '0;
      rst_uut     <= 1'b1;
      block_i_uut <= '0;
      key_uut     <= '0;
      endec_uut   <= 1'b0;
`ifdef PRESENT_UUT_DRIVER_KEY_CYCLES_EN
      key_cycles_o <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rst_uut <= 1'b1;
          if (start) begin
            block_i_uut <= vec_block_i;
            key_uut     <= vec_key_i;
            endec_uut   <= vec_endec_i;
            busy        <= 1'b1;
            timeout_o   <= 1'b0;
            rst_cnt     <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
            rst_uut <= 1'b0;
            state   <= KEYGEN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        KEYGEN: begin
          if (end_key_signal_uut) begin
            state <= RUN;
`ifdef PRESENT_UUT_DRIVER_KEY_CYCLES_EN
            // Include the cycle end_key was seen in, like cycles_o does.
            key_cycles_o <= count + 1'b1;
`endif
          end else if (at_limit) begin
            timeout_o <= 1'b1;
            result_o  <= '0;
            cycles_o  <= TO_VAL;
            state     <= DONE;
`ifdef PRESENT_UUT_DRIVER_KEY_CYCLES_EN
            key_cycles_o <= '0;
`endif
          end
        end
        RUN: begin
          if (strobe) begin
            state <= CAPTURE;
          end else if (at_limit) begin
            timeout_o <= 1'b1;
            result_o  <= '0;
            cycles_o  <= TO_VAL;
            state     <= DONE;
          end
        end
        CAPTURE: begin
          result_o <= block_o_uut;
          cycles_o <= count;
          state    <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          rst_uut <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/present_uut_driver.md
Name: present_uut_driver

Overview:
Sequencer that sits between the autotest control FSM and the PRESENT cipher under test.
- Latches one test vector: block, key, direction.
- Resets and launches the UUT, then waits for the key schedule and the enc/dec completion strobes.
- Counts elapsed cycles, captures the output block, and returns result, cycle count and timeout flag to the FSM for write-back to SD.

Parameters:
- BLOCK_SIZE, 64, cipher data block width
- KEY_INPUT_SIZE, 80, cipher key width
- CNT_WIDTH, 32, cycle counter width
- RST_CYCLES, 4, clocks rst_uut is held asserted per launch (>=1)
- TIMEOUT_CYCLES, 100000, abort threshold measured from rst_uut release

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- start  in  1  launch request, sampled in IDLE only
- vec_block_i  in  BLOCK_SIZE  plaintext/ciphertext vector
- vec_key_i  in  KEY_INPUT_SIZE  key vector
- vec_endec_i  in  1  0=encrypt, 1=decrypt
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, result fields valid
- result_o  out  BLOCK_SIZE  captured block_o_uut
- cycles_o  out  CNT_WIDTH  cycles from rst_uut release to completion strobe
- timeout_o  out  1  run aborted by timeout
- rst_uut  out  1  active-high UUT reset
- block_i_uut  out  BLOCK_SIZE  held vector block
- key_uut  out  KEY_INPUT_SIZE  held vector key
- endec_uut  out  1  held direction
- block_o_uut  in  BLOCK_SIZE  UUT result
- end_key_signal_uut  in  1  key schedule complete (level)
- end_enc_uut  in  1  encryption complete (level)
- end_dec_uut  in  1  decryption complete (level)

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; busy=0, done=0, timeout_o=0, result_o=0, cycles_o=0, rst_uut=1, block_i_uut=0, key_uut=0, endec_uut=0. Reset mid-run aborts immediately with no done pulse.
- IDLE: rst_uut=1. If start=1, latch vec_* into the UUT output registers, busy<=1, clear timeout_o, go to LOAD.
- LOAD: rst_uut=1 for exactly RST_CYCLES clocks, then rst_uut<=0, cycle counter<=0, go to KEYGEN.
- KEYGEN: counter +1 per clock. end_key_signal_uut=1 -> RUN.
- RUN: counter +1 per clock. Completion strobe is end_enc_uut when endec_uut=0, end_dec_uut when endec_uut=1. The other strobe is ignored.
- Completion strobe sampled high -> CAPTURE. The strobe may rise in the same cycle as end_key; KEYGEN then moves to RUN and completion is taken on the next clock.
- CAPTURE: result_o<=block_o_uut, cycles_o<=counter, go to DONE.
- DONE: done=1 for one cycle, busy<=0, rst_uut<=1, return to IDLE. Outputs hold until the next accepted start.
- Timeout: in KEYGEN or RUN, counter==TIMEOUT_CYCLES-1 with no strobe -> timeout_o<=1, result_o<=0, cycles_o<=TIMEOUT_CYCLES, go to DONE. If the strobe and the timeout coincide, the strobe wins.
- Counter saturates at all-ones; it never wraps.
- start while busy is ignored, and start is not queued.
- Vector outputs to the UUT are stable from LOAD through DONE.
- Latency, start to done, with K = key cycles and R = run cycles: RST_CYCLES + K + R + 3 clocks.

Optional Feature:
- Macro PRESENT_UUT_DRIVER_KEY_CYCLES_EN.
- Defined: extra output key_cycles_o [CNT_WIDTH], loaded with the counter value on KEYGEN->RUN. Reset 0; 0 on timeout in KEYGEN.
- Undefined: port and register are absent, and cycles_o is unchanged.

Decomposition:
- autotest_pkg holds:
  - the driver_state_t enum {IDLE, LOAD, KEYGEN, RUN, CAPTURE, DONE};
  - the ENDEC_ENC/ENDEC_DEC constants;
  - the default widths and TIMEOUT_CYCLES.
- The cycle counter is the existing generic counter module (up=1, reload via its reset), instantiated once.
- No other sub-module.

Test Plan:
1. Encrypt zero vector: start with block=0, key=0, endec=0; model raises end_key after 32 cycles and end_enc 31 cycles later -> result_o=0x5579C1387B228445, cycles_o=63, done pulse once, timeout_o=0.
2. Decrypt path: endec=1; model raises end_enc (ignored) then end_dec after 40 cycles -> capture on end_dec only; cycles_o counts to end_dec.
3. Timeout: TIMEOUT_CYCLES=100, model never raises end_key -> done after 100 counted cycles; timeout_o=1, cycles_o=100, result_o=0.
4. Start while busy: second start mid-RUN with a different key -> ignored; key_uut unchanged until DONE; exactly one done pulse.
5. Reset mid-RUN: rst=0 for 1 cycle -> next cycle IDLE, rst_uut=1, busy=0, no done; a fresh start then completes normally.
6. Simultaneous strobes: end_key and end_enc rise in the same cycle -> done exactly 3 cycles later with the correct cycles_o; with the macro defined, key_cycles_o equals the key latency.
